ov7670_init_sequencer: RTL
==========================

Name: ov7670_init_sequencer

Overview:
- Drives the camera's SCCB/I2C byte engine from a register-initialisation table, sitting directly upstream of that engine.
- On start, walks a ROM of {register, value} pairs. Each entry becomes one 3-byte write: device address, register, value.
- ROM entries can also encode a wait or the end of the table.
- Reports done or error to the top-level camera controller.

Parameters:
- DEV_ADDR, 8'h42, SCCB write address of the OV7670.
- ROM_AW, 8, address width of the init table (max 256 entries).
- DELAY_UNIT, 50000, clk cycles per delay tick (1 ms at 50 MHz).
- BUSY_TIMEOUT, 1023, max cycles from strobe to engine busy-high before error.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high.
- start  in  1  one-cycle pulse; begins table walk when idle.
- i2cBusy  in  1  busy from byte engine.
- i2cStrobe  out  1  request to engine to send dataToSend.
- dataToSend  out  8  byte presented to engine.
- lastTransfer  out  1  high with the third byte of each write; engine issues stop after it.
- busy  out  1  high whenever state != IDLE/DONE/ERROR.
- done  out  1  sticky; table completed.
- error  out  1  sticky; engine failed to go busy within BUSY_TIMEOUT.
- entryIdx  out  ROM_AW  current table index, for debug.

Behaviour:
- Reset: state IDLE; i2cStrobe=0, dataToSend=0, lastTransfer=0, done=0, error=0, entryIdx=0, counters=0.
- ROM: 16-bit words {reg[15:8], val[7:0]}, synchronous read, 1-cycle latency.
  - 16'hFFFF = end of table.
  - 16'hFFnn (nn != FF) = delay of nn*DELAY_UNIT cycles; nn=0 means no delay.
  - All other words = register write.
- States:
  - IDLE: on start, clear done/error, entryIdx=0, go FETCH. start is ignored outside IDLE/DONE/ERROR.
  - FETCH: present address entryIdx; next cycle go DECODE.
  - DECODE: latch word.
    - End marker -> DONE.
    - Delay word -> DELAY, load counter.
    - Otherwise byteSel=0 -> STROBE.
  - STROBE: dataToSend = byteSel 0/1/2 ? DEV_ADDR/reg/val; lastTransfer = (byteSel==2); i2cStrobe=1; start timeout counter; go WAIT_HI.
    - dataToSend and lastTransfer are driven from STROBE until WAIT_LO exits. The engine samples continuously while idle, so both must be stable at least one cycle before strobe; they are registered one cycle early.
  - WAIT_HI: hold i2cStrobe=1 until i2cBusy=1, then drop strobe and go WAIT_LO. If timeout reaches BUSY_TIMEOUT first -> ERROR with strobe 0.
  - WAIT_LO: wait for i2cBusy=0. Then if byteSel<2: byteSel++ -> STROBE; else entryIdx++ -> FETCH.
  - DELAY: count down to 0, then entryIdx++ -> FETCH.
  - DONE: done=1, remain until start (restart walk).
  - ERROR: error=1, remain until start.
- entryIdx wrap: if entryIdx reaches 2^ROM_AW-1 without an end marker, that word is still processed; the increment past the last index goes DONE (no wrap to 0).
- Strobe is never asserted while i2cBusy=1 on entry to STROBE. If busy is high there, hold in STROBE with strobe low until it falls.
- Reset mid-operation: immediate return to reset values. The engine is reset by the same signal, so no partial-write recovery is needed.
- Delay counter width: ceil(log2(255*DELAY_UNIT+1)).

Decomposition:
- Shared package ov7670_pkg holds:
  - seq state enum;
  - constants ROM_END=16'hFFFF and ROM_DELAY_TAG=8'hFF;
  - DEV_ADDR default.
- Sub-module ov7670_init_rom: synchronous ROM, address in, 16-bit data out, table contents.
  - Default table starts with {8'h12,8'h80} (soft reset), then 16'hFF0A (10 ms), then the register list, ending with 16'hFFFF.

Test Plan:
- ROM {12 80, FFFF} with an engine model (busy high 1 cycle after strobe, 20 cycles long) -> three strobes with bytes 42, 12, 80; lastTransfer only on 80; then done=1, busy=0.
- ROM {FF02, 3A 04, FFFF}, DELAY_UNIT=10 -> first strobe no earlier than 20 cycles after DECODE of entry 0; bytes 42, 3A, 04; done=1.
- Engine model never raises busy, BUSY_TIMEOUT=15 -> error=1 at 16 cycles after strobe; i2cStrobe=0; no further bytes.
- Reset asserted during WAIT_LO of byte 2 -> all outputs to reset values the same cycle; later start replays from entryIdx=0.
- start pulsed while busy -> ignored, byte sequence unchanged. start in DONE -> done clears, table replays identically.
- i2cBusy held high at start -> no strobe until busy falls; then normal 42/reg/val sequence.

Source files
------------

// File: rtl/ov7670_pkg.sv
// Shared types and constants for the OV7670 register-initialisation sequencer.
package ov7670_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_STROBE,
    S_WAIT_HI,
    S_WAIT_LO,
    S_DELAY,
    S_DONE,
    S_ERROR
  } seq_state_t;

  localparam logic [15:0] ROM_END          = 16'hFFFF;
  localparam logic [7:0]  ROM_DELAY_TAG    = 8'hFF;
  localparam logic [7:0]  DEV_ADDR_DEFAULT = 8'h42;

  // Capacity of the override table that replaces the built-in list.
  localparam int USER_TABLE_MAX = 16;

endpackage

// File: rtl/ov7670_init_rom.sv
// Init table ROM: {reg, val} words, one-cycle synchronous read.
// Entries beyond the table read as the end marker.
module ov7670_init_rom
  import ov7670_pkg::*;
#(
  parameter int                          ROM_AW     = 8,
  parameter int                          USER_LEN   = 0,
  parameter logic [USER_TABLE_MAX*16-1:0] USER_TABLE = '0
) (
  input  logic              clk,
  input  logic [ROM_AW-1:0] addr,
  output logic [15:0]       data
);

  function automatic logic [15:0] default_word(input int idx);
    case (idx)
      0:       return 16'h1280;  // COM7: soft reset
      1:       return 16'hFF0A;  // settle 10 ticks after reset
      2:       return 16'h1101;  // CLKRC
      3:       return 16'h1204;  // COM7: RGB output
      4:       return 16'h0C00;  // COM3
      5:       return 16'h3E00;  // COM14
      6:       return 16'h40D0;  // COM15: RGB565, full range
      7:       return 16'h3A04;  // TSLB
      8:       return 16'h1418;  // COM9: AGC ceiling
      9:       return 16'h8C00;  // RGB444 off
      default: return ROM_END;
    endcase
  endfunction

  logic [15:0] word;
  int          idx;

  // NOTE: every variable written in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    idx  = int'(addr);
    word = ROM_END;
    if (USER_LEN > 0) begin
      if (idx < USER_LEN && idx < USER_TABLE_MAX) word = USER_TABLE[idx*16 +: 16];
    end else begin
      word = default_word(idx);
    end
  end

  // NOTE: the read register has no reset; the sequencer only decodes it after a FETCH loads it.
  always_ff @(posedge clk) begin
    data <= word;
  end

endmodule

// File: rtl/ov7670_init_sequencer.sv
// Walks the init table and feeds the SCCB byte engine three bytes per register write,
// honouring delay entries and reporting done or error upstream.
module ov7670_init_sequencer
  import ov7670_pkg::*;
#(
  parameter logic [7:0]                   DEV_ADDR     = DEV_ADDR_DEFAULT,
  parameter int                           ROM_AW       = 8,
  parameter int                           DELAY_UNIT   = 50000,
  parameter int                           BUSY_TIMEOUT = 1023,
  parameter int                           USER_LEN     = 0,
  parameter logic [USER_TABLE_MAX*16-1:0] USER_TABLE   = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              i2cBusy,
  output logic              i2cStrobe,
  output logic [7:0]        dataToSend,
  output logic              lastTransfer,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ROM_AW-1:0] entryIdx
);

  localparam int DELAY_W   = $clog2(255 * DELAY_UNIT + 1);
  localparam int TIMEOUT_W = (BUSY_TIMEOUT > 0) ? $clog2(BUSY_TIMEOUT + 1) : 1;
  localparam logic [ROM_AW-1:0] LAST_IDX = '1;

  seq_state_t           state;
  logic [1:0]           byte_sel;
  logic [7:0]           reg_byte;
  logic [7:0]           val_byte;
  logic [DELAY_W-1:0]   delay_cnt;
  logic [TIMEOUT_W-1:0] timeout_cnt;
  logic [15:0]          rom_data;

  ov7670_init_rom #(
    .ROM_AW    (ROM_AW),
    .USER_LEN  (USER_LEN),
    .USER_TABLE(USER_TABLE)
  ) u_rom (
    .clk (clk),
    .addr(entryIdx),
    .data(rom_data)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      byte_sel     <= '0;
      reg_byte     <= '0;
      val_byte     <= '0;
      delay_cnt    <= '0;
      timeout_cnt  <= '0;
      i2cStrobe    <= 1'b0;
      dataToSend   <= '0;
      lastTransfer <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
      entryIdx     <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (start) begin
            done     <= 1'b0;
            error    <= 1'b0;
            entryIdx <= '0;
            busy     <= 1'b1;
            state    <= S_FETCH;
          end
        end
        S_FETCH: state <= S_DECODE;
        S_DECODE: begin
          reg_byte <= rom_data[15:8];
          val_byte <= rom_data[7:0];
          if (rom_data == ROM_END) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= S_DONE;
          end else if (rom_data[15:8] == ROM_DELAY_TAG) begin
            delay_cnt <= DELAY_W'(32'(rom_data[7:0]) * 32'(DELAY_UNIT));
            state     <= S_DELAY;
          end else begin
            // Byte is presented a cycle ahead of the strobe; the engine samples while idle.
            byte_sel     <= 2'd0;
            dataToSend   <= DEV_ADDR;
            lastTransfer <= 1'b0;
            state        <= S_STROBE;
          end
        end
        S_STROBE: begin
          if (!i2cBusy) begin
            i2cStrobe   <= 1'b1;
            timeout_cnt <= '0;
            state       <= S_WAIT_HI;
          end
        end
        S_WAIT_HI: begin
          if (i2cBusy) begin
            i2cStrobe <= 1'b0;
            state     <= S_WAIT_LO;
          end else if (timeout_cnt == TIMEOUT_W'(BUSY_TIMEOUT)) begin
            i2cStrobe <= 1'b0;
            error     <= 1'b1;
            busy      <= 1'b0;
            state     <= S_ERROR;
          end else begin
            timeout_cnt <= timeout_cnt + 1'b1;
          end
        end
        S_WAIT_LO: begin
          if (!i2cBusy) begin
            if (byte_sel != 2'd2) begin
              byte_sel     <= byte_sel + 2'd1;
              dataToSend   <= (byte_sel == 2'd0) ? reg_byte : val_byte;
              lastTransfer <= (byte_sel == 2'd1);
              state        <= S_STROBE;
            end else begin
              dataToSend   <= '0;
              lastTransfer <= 1'b0;
              if (entryIdx == LAST_IDX) begin
                done  <= 1'b1;
                busy  <= 1'b0;
                state <= S_DONE;
              end else begin
                entryIdx <= entryIdx + 1'b1;
                state    <= S_FETCH;
              end
            end
          end
        end
        S_DELAY: begin
          if (delay_cnt == '0) begin
            // The last table slot never wraps back to entry 0.
            if (entryIdx == LAST_IDX) begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= S_DONE;
            end else begin
              entryIdx <= entryIdx + 1'b1;
              state    <= S_FETCH;
            end
          end else begin
            delay_cnt <= delay_cnt - 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
